// File: rtl/ir_tx_encoder.sv
// ir_tx_encoder
// Transmit side of the pulse-width IR link. Serialises a 32-bit word into
// one start pulse followed by 32 data pulses, MSB first. Each pulse is a
// high interval whose width encodes the symbol (long = start, medium = 1,
// short = 0), and each pulse is followed by a fixed low gap.
//
// Ports:
//   clk      10 kHz IR clock, rising-edge active
//   reset    asynchronous, active-high reset
//   send     frame request, level-sampled (one frame per assertion)
//   tx_data  word to transmit, latched when a frame is accepted
//   busy     high while a frame is in progress
//   done     one-cycle pulse when a frame completes
//   ir_out   registered IR emitter drive, high = pulse
//
// Optional feature macro: IR_TX_REPEAT_EN
//   When defined, holding send high repeats the frame after a low
//   inter-frame gap of 4*GAP_W cycles, re-latching tx_data each time.

module ir_tx_encoder #(
    parameter int START_W = 15,
    parameter int ONE_W   = 12,
    parameter int ZERO_W  = 6,
    parameter int GAP_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [31:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic        ir_out
);

    // Terminal counts for the 4-bit width counter: a phase ends when the
    // counter reaches its width minus one.
    localparam logic [3:0] START_LAST = 4'(START_W - 1);
    localparam logic [3:0] ONE_LAST   = 4'(ONE_W - 1);
    localparam logic [3:0] ZERO_LAST  = 4'(ZERO_W - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_HI,
        GAP,
        BIT_HI
`ifdef IR_TX_REPEAT_EN
        , FRAME_GAP
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] shreg, shreg_nxt;
    logic [4:0]  bit_idx, bit_idx_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last_bit, last_bit_nxt;
    logic        armed, armed_nxt;
    logic        done_nxt;
    logic        ir_nxt;
    logic        busy_nxt;
    logic [3:0]  bit_last;

`ifdef IR_TX_REPEAT_EN
    // The inter-frame gap is longer than 15 cycles, so it gets its own counter.
    localparam logic [5:0] FGAP_LAST = 6'(4 * GAP_W - 1);
    logic [5:0]  fcnt, fcnt_nxt;
`endif

    // State register. All outputs are registered from next-state values so
    // that ir_out is glitch-free and the async reset drops it immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= 5'd31;
            cnt      <= '0;
            last_bit <= 1'b0;
            armed    <= 1'b1;
            done     <= 1'b0;
            ir_out   <= 1'b0;
            busy     <= 1'b0;
`ifdef IR_TX_REPEAT_EN
            fcnt     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_idx  <= bit_idx_nxt;
            cnt      <= cnt_nxt;
            last_bit <= last_bit_nxt;
            armed    <= armed_nxt;
            done     <= done_nxt;
            ir_out   <= ir_nxt;
            busy     <= busy_nxt;
`ifdef IR_TX_REPEAT_EN
            fcnt     <= fcnt_nxt;
`endif
        end
    end

    // Next-state logic. A frame is accepted only when armed, and armed only
    // returns once send has been seen low, so a held send yields one frame.
    // last_bit remembers that bit 0 has been sent so the following gap can
    // tell the end of the frame apart from the gap after the start pulse.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_idx_nxt  = bit_idx;
        cnt_nxt      = cnt;
        last_bit_nxt = last_bit;
        armed_nxt    = armed | ~send;
        done_nxt     = 1'b0;
        bit_last     = shreg[31] ? ONE_LAST : ZERO_LAST;
`ifdef IR_TX_REPEAT_EN
        fcnt_nxt     = fcnt;
`endif

        case (state)
            IDLE: begin
                if (send && armed) begin
                    shreg_nxt    = tx_data;
                    bit_idx_nxt  = 5'd31;
                    cnt_nxt      = '0;
                    last_bit_nxt = 1'b0;
                    armed_nxt    = 1'b0;
                    state_nxt    = START_HI;
                end
            end
            START_HI: begin
                if (cnt == START_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (last_bit) begin
                        done_nxt  = 1'b1;
`ifdef IR_TX_REPEAT_EN
                        if (send) begin
                            fcnt_nxt  = '0;
                            state_nxt = FRAME_GAP;
                        end else begin
                            state_nxt = IDLE;
                        end
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = BIT_HI;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            BIT_HI: begin
                if (cnt == bit_last) begin
                    cnt_nxt      = '0;
                    shreg_nxt    = {shreg[30:0], 1'b0};
                    bit_idx_nxt  = bit_idx - 5'd1;
                    last_bit_nxt = (bit_idx == 5'd0);
                    state_nxt    = GAP;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
`ifdef IR_TX_REPEAT_EN
            FRAME_GAP: begin
                if (fcnt == FGAP_LAST) begin
                    if (send) begin
                        shreg_nxt    = tx_data;
                        bit_idx_nxt  = 5'd31;
                        cnt_nxt      = '0;
                        last_bit_nxt = 1'b0;
                        state_nxt    = START_HI;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    fcnt_nxt = fcnt + 6'd1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        ir_nxt   = (state_nxt == START_HI) || (state_nxt == BIT_HI);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_ir_tx_encoder.sv
// tb_ir_tx_encoder
// Self-checking bench for ir_tx_encoder. The reference model builds the
// expected ir_out waveform of a frame directly from the symbol widths.

module tb_ir_tx_encoder;

    localparam int START_W = 15;
    localparam int ONE_W   = 12;
    localparam int ZERO_W  = 6;
    localparam int GAP_W   = 4;

    logic        clk;
    logic        reset;
    logic        send;
    logic [31:0] tx_data;
    logic        busy;
    logic        done;
    logic        ir_out;

    int checks;
    int passes;

    bit expWave[$];

    typedef struct {
        logic [31:0] word;
        int          expLen;
    } vec_t;

    vec_t vecs[5];

    ir_tx_encoder #(
        .START_W(START_W),
        .ONE_W  (ONE_W),
        .ZERO_W (ZERO_W),
        .GAP_W  (GAP_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .send   (send),
        .tx_data(tx_data),
        .busy   (busy),
        .done   (done),
        .ir_out (ir_out)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected high/low sequence of one frame, one entry per clock cycle.
    function automatic void buildModel(input logic [31:0] w);
        expWave.delete();
        for (int i = 0; i < START_W; i++) expWave.push_back(1'b1);
        for (int i = 0; i < GAP_W; i++)   expWave.push_back(1'b0);
        for (int b = 31; b >= 0; b--) begin
            int wd;
            wd = w[b] ? ONE_W : ZERO_W;
            for (int i = 0; i < wd; i++)    expWave.push_back(1'b1);
            for (int i = 0; i < GAP_W; i++) expWave.push_back(1'b0);
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Drive inputs on the falling edge, away from the active edge.
    task automatic applyStimulus(input logic s, input logic [31:0] d);
        @(negedge clk);
        send    = s;
        tx_data = d;
    endtask

    // Wait (bounded) until the encoder is idle with no done pulse pending.
    task automatic waitIdle(input string name);
        int cyc = 0;
        while ((busy || done) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({name, " idle timeout"}, int'(cyc < 3000), 1);
    endtask

    // Request a single frame and compare the emitted waveform with the
    // model. expLen < 0 skips the fixed-length check. At frame cycle
    // changeAt tx_data is overwritten to show the latched word is kept.
    task automatic runFrame(input logic [31:0] word, input int expLen, input string name,
                            input int changeAt, input logic [31:0] changeVal);
        int len = 0;
        int mism = 0;
        int firstBad = -1;
        int doneIn = 0;
        int cyc = 0;
        bit ended = 0;
        logic endDone = 1'b0;
        buildModel(word);
        applyStimulus(1'b1, word);
        applyStimulus(1'b0, word);
        while (!ended && cyc < 1000) begin
            if (busy) begin
                if (len >= expWave.size() || ir_out !== expWave[len]) begin
                    mism++;
                    if (firstBad < 0) firstBad = len;
                end
                if (done) doneIn++;
                len++;
                if (len == changeAt) tx_data = changeVal;
            end else begin
                ended   = 1;
                endDone = done;
            end
            if (!ended) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({name, " timeout"}, int'(ended), 1);
        if (expLen >= 0) checkOutput({name, " length"}, len, expLen);
        checkOutput({name, " model length"}, len, expWave.size());
        if (mism != 0) $display("[TB] first bad cycle %0d in %s", firstBad, name);
        checkOutput({name, " waveform errors"}, mism, 0);
        checkOutput({name, " done while busy"}, doneIn, 0);
        checkOutput({name, " done at end"}, int'(endDone), 1);
        @(negedge clk);
        checkOutput({name, " done one cycle"}, int'(done), 0);
        checkOutput({name, " ir_out after"}, int'(ir_out), 0);
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        reset   = 1'b1;
        send    = 1'b0;
        tx_data = '0;

        vecs[0] = '{32'h0000_0000, 339};
        vecs[1] = '{32'hA5A5_A5A5, 435};
        vecs[2] = '{32'hFFFF_FFFF, 531};
        vecs[3] = '{32'h8000_0000, 345};
        vecs[4] = '{32'h0000_0001, 345};

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset ir_out", int'(ir_out), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle busy", int'(busy), 0);

        // Table-driven single frames.
        for (int i = 0; i < 5; i++) begin
            runFrame(vecs[i].word, vecs[i].expLen, $sformatf("vec%0d", i), -1, '0);
        end

        // tx_data changes mid-frame are ignored.
        runFrame(32'h1234_5678, 417, "latched word", 100, 32'h0);

        // Randomized words against the model.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            w = $urandom;
            runFrame(w, -1, $sformatf("rand%0d", i), -1, '0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifndef IR_TX_REPEAT_EN
        // Held send gives exactly one frame; a one-cycle drop re-arms.
        begin
            int frames = 0;
            int busyCyc = 0;
            int dones = 0;
            logic prevBusy = 1'b0;
            applyStimulus(1'b1, 32'hFFFF_FFFF);
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (busy && !prevBusy) frames++;
                if (busy) busyCyc++;
                if (done) dones++;
                prevBusy = busy;
            end
            checkOutput("hold frames", frames, 1);
            checkOutput("hold busy cycles", busyCyc, 531);
            checkOutput("hold done count", dones, 1);
            applyStimulus(1'b0, 32'hFFFF_FFFF);
            applyStimulus(1'b1, 32'hFFFF_FFFF);
            @(negedge clk);
            checkOutput("rearm busy", int'(busy), 1);
            checkOutput("rearm ir_out", int'(ir_out), 1);
            send = 1'b0;
            waitIdle("rearm");
        end
`endif

        // Asynchronous reset mid-frame.
        begin
            int doneSeen = 0;
            applyStimulus(1'b1, 32'hFFFF_FFFF);
            applyStimulus(1'b0, 32'hFFFF_FFFF);
            repeat (200) @(negedge clk);
            checkOutput("pre-reset ir_out", int'(ir_out), 1);
            #2 reset = 1'b1;
            #1;
            checkOutput("async reset ir_out", int'(ir_out), 0);
            checkOutput("async reset busy", int'(busy), 0);
            if (done) doneSeen++;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done) doneSeen++;
            end
            reset = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done) doneSeen++;
            end
            checkOutput("abandoned done", doneSeen, 0);
            runFrame(32'h0000_0001, 345, "post-reset", -1, '0);
        end

`ifdef IR_TX_REPEAT_EN
        // Repeat mode: frame, 16 low cycles, frame, with one done per frame.
        begin
            bit full[$];
            int mism = 0;
            int dones = 0;
            buildModel(32'h0);
            full = expWave;
            for (int i = 0; i < 4 * GAP_W; i++) full.push_back(1'b0);
            for (int i = 0; i < expWave.size(); i++) full.push_back(expWave[i]);
            applyStimulus(1'b1, 32'h0);
            @(negedge clk);
            for (int i = 0; i <= full.size(); i++) begin
                if (i < full.size() && ir_out !== full[i]) mism++;
                if (done) dones++;
                if (i == 400) send = 1'b0;
                if (i < full.size()) @(negedge clk);
            end
            checkOutput("repeat waveform errors", mism, 0);
            checkOutput("repeat done count", dones, 2);
            checkOutput("repeat end busy", int'(busy), 0);
            waitIdle("repeat");
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
